// File: rtl/rng_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rng_pkg
// Purpose  : Shared types and default constants for the RNG byte collector.
//            Holds the collector FSM state type and the default values for
//            the FIFO depth and the repetition-count limit.
// Revision : 1.0 - initial release
// ============================================================================
package rng_pkg;

    localparam int c_fifo_depth = 4;   // byte entries buffered
    localparam int c_rep_limit  = 16;  // identical-bit run that trips health

    typedef enum logic [0:0] {
        ST_COLLECT = 1'b0,
        ST_FAIL    = 1'b1
    } rng_state_t;

endpackage : rng_pkg
`default_nettype wire

// File: rtl/rng_fifo.sv
`default_nettype none
// ============================================================================
// Module   : rng_fifo
// Purpose  : Synchronous FIFO with registered storage. The head entry is read
//            straight from the storage array, so rd_data only changes on a
//            clock edge. A push into a full FIFO is accepted when a pop
//            happens in the same cycle.
// Ports    : clk, rst_n (async, active-high)
//            push, push_data   - write request and data
//            pop               - read request (ignored when empty)
//            rd_data           - head entry
//            count, full, empty- occupancy status
// Revision : 1.0 - initial release
// ============================================================================
module rng_fifo
    import rng_pkg::*;
#(
    parameter int DEPTH = c_fifo_depth,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   c_full_count = DEPTH[AW:0];
    localparam logic [AW:0]   c_cnt_one    = 1;
    localparam logic [AW-1:0] c_ptr_one    = 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_pop;
    logic             w_push;

    assign full    = (r_count == c_full_count);
    assign empty   = (r_count == '0);
    assign count   = r_count;
    assign rd_data = r_mem[r_rd_ptr];

    // When full, the slot being pushed is the one being popped, so both can
    // proceed together.
    assign w_pop  = pop && !empty;
    assign w_push = push && (!full || w_pop);

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= push_data;
                r_wr_ptr        <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule : rng_fifo
`default_nettype wire

// File: rtl/rng_byte_collector.sv
`default_nettype none
// ============================================================================
// Module   : rng_byte_collector
// Purpose  : Packs a serial random bitstream LSB-first into bytes and buffers
//            them in a FIFO for a ready/valid consumer. An optional
//            repetition-count health test stops collection when too many
//            identical bits arrive in a row.
// Config   : RNG_HEALTH_TEST_EN - when defined, builds the repetition-count
//            test and the FAIL state; otherwise health_fail is tied low and
//            clear_fail only clears overflow.
// Ports    : clk, rst_n (async, active-high)
//            bit_in, bit_valid - serial bit input
//            clear_fail        - clears sticky flags and leaves FAIL
//            byte_data, byte_valid, byte_ready - byte output handshake
//            fifo_count        - occupied FIFO entries
//            overflow          - sticky, a completed byte was dropped
//            health_fail       - sticky, the repetition test tripped
// Revision : 1.0 - initial release
// ============================================================================
module rng_byte_collector
    import rng_pkg::*;
#(
    parameter int FIFO_DEPTH = c_fifo_depth,
    parameter int REP_LIMIT  = c_rep_limit
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          bit_in,
    input  logic                          bit_valid,
    input  logic                          clear_fail,
    output logic [7:0]                    byte_data,
    output logic                          byte_valid,
    input  logic                          byte_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    output logic                          health_fail
);

    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_fifo_depth
        $error("FIFO_DEPTH must be a power of two, at least 2");
    end
    if (REP_LIMIT < 2) begin : g_bad_rep_limit
        $error("REP_LIMIT must be at least 2");
    end

    logic [7:0] r_shift;
    logic [2:0] r_bit_cnt;
    logic       r_overflow;
    logic [7:0] w_byte;
    logic       w_collecting;
    logic       w_trip;
    logic       w_accept;
    logic       w_complete;
    logic       w_push;
    logic       w_pop;
    logic       w_full;
    logic       w_empty;

    // A coinciding clear_fail takes priority over the offered bit.
    assign w_accept   = bit_valid && w_collecting && !clear_fail;
    // Shift right with the new bit entering at the MSB: after eight shifts
    // the first bit sits in bit 0.
    assign w_byte     = {bit_in, r_shift[7:1]};
    assign w_complete = w_accept && (r_bit_cnt == 3'd7);
    assign w_push     = w_complete && !w_trip;
    assign w_pop      = byte_valid && byte_ready;
    assign byte_valid = !w_empty;
    assign overflow   = r_overflow;

    // Bit counter wraps to 0 after the eighth bit whether or not the byte
    // found room in the FIFO.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_shift   <= '0;
            r_bit_cnt <= '0;
        end else if (w_trip) begin
            r_shift   <= '0;
            r_bit_cnt <= '0;
        end else if (w_accept) begin
            r_shift   <= w_byte;
            r_bit_cnt <= r_bit_cnt + 3'd1;
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_overflow <= 1'b0;
        end else if (clear_fail) begin
            r_overflow <= 1'b0;
        end else if (w_push && w_full && !w_pop) begin
            r_overflow <= 1'b1;
        end
    end

`ifdef RNG_HEALTH_TEST_EN
    localparam int RW = $clog2(REP_LIMIT + 1);
    localparam logic [RW-1:0] c_rep_max = REP_LIMIT[RW-1:0];
    localparam logic [RW-1:0] c_rep_one = 1;

    rng_state_t    r_state;
    rng_state_t    w_state_next;
    logic [RW-1:0] r_rep_cnt;
    logic [RW-1:0] w_rep_next;
    logic          r_last_bit;
    logic          r_health_fail;

    // rep_cnt of 0 marks "no bit seen since reset/clear", so the next bit
    // always starts a fresh run.
    assign w_rep_next   = ((r_rep_cnt == '0) || (bit_in != r_last_bit)) ?
                          c_rep_one : (r_rep_cnt + c_rep_one);
    assign w_trip       = w_accept && (w_rep_next == c_rep_max);
    assign w_collecting = (r_state == ST_COLLECT);
    assign health_fail  = r_health_fail;

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_state <= ST_COLLECT;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_COLLECT: if (w_trip)     w_state_next = ST_FAIL;
            ST_FAIL:    if (clear_fail) w_state_next = ST_COLLECT;
            default:                    w_state_next = ST_COLLECT;
        endcase
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_rep_cnt     <= '0;
            r_last_bit    <= 1'b0;
            r_health_fail <= 1'b0;
        end else if (clear_fail) begin
            r_rep_cnt     <= '0;
            r_health_fail <= 1'b0;
        end else if (w_accept) begin
            r_rep_cnt  <= w_rep_next;
            r_last_bit <= bit_in;
            if (w_trip) begin
                r_health_fail <= 1'b1;
            end
        end
    end
`else
    assign w_collecting = 1'b1;
    assign w_trip       = 1'b0;
    assign health_fail  = 1'b0;
`endif

    rng_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (w_push),
        .push_data (w_byte),
        .pop       (w_pop),
        .rd_data   (byte_data),
        .count     (fifo_count),
        .full      (w_full),
        .empty     (w_empty)
    );

endmodule : rng_byte_collector
`default_nettype wire

// File: tb/tb_rng_byte_collector.sv
`default_nettype none
// ============================================================================
// Module   : tb_rng_byte_collector
// Purpose  : Self-checking bench for rng_byte_collector. A behavioural model
//            (byte queue plus run-length arithmetic) predicts the outputs
//            every cycle; directed tables and sequences cover the corner
//            cases, followed by a randomized stream.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rng_byte_collector;

    localparam int DEPTH = 4;
    localparam int REP   = 16;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk        = 1'b0;
    logic          rst_n      = 1'b1;
    logic          bit_in     = 1'b0;
    logic          bit_valid  = 1'b0;
    logic          clear_fail = 1'b0;
    logic          byte_ready = 1'b0;
    logic [7:0]    byte_data;
    logic          byte_valid;
    logic [CW-1:0] fifo_count;
    logic          overflow;
    logic          health_fail;

    rng_byte_collector #(
        .FIFO_DEPTH (DEPTH),
        .REP_LIMIT  (REP)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bit_in      (bit_in),
        .bit_valid   (bit_valid),
        .clear_fail  (clear_fail),
        .byte_data   (byte_data),
        .byte_valid  (byte_valid),
        .byte_ready  (byte_ready),
        .fifo_count  (fifo_count),
        .overflow    (overflow),
        .health_fail (health_fail)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    logic [7:0] m_q[$];
    int         m_acc;
    int         m_nbits;
    int         m_run;
    bit         m_last;
    bit         m_ovf;
    bit         m_hf;
    bit         m_fail;

    task automatic model_reset();
        m_q.delete();
        m_acc = 0; m_nbits = 0; m_run = 0; m_last = 1'b0;
        m_ovf = 1'b0; m_hf = 1'b0; m_fail = 1'b0;
    endtask

    task automatic model_step(input bit bv, input bit b, input bit rdy, input bit clr);
        bit         pop;
        bit         push;
        bit         acc;
        logic [7:0] pv;
        pop  = rdy && (m_q.size() > 0);
        push = 1'b0;
        pv   = '0;
        acc  = bv && !clr && !m_fail;
        if (clr) begin
            m_ovf = 1'b0; m_hf = 1'b0; m_fail = 1'b0; m_run = 0;
        end
        if (acc) begin
            m_acc = m_acc | (int'(b) << m_nbits);
            m_nbits++;
`ifdef RNG_HEALTH_TEST_EN
            if (m_run == 0 || b != m_last) m_run = 1;
            else                           m_run++;
            m_last = b;
            if (m_run == REP) begin
                m_fail = 1'b1; m_hf = 1'b1; m_nbits = 0; m_acc = 0;
            end
`endif
            if (m_nbits == 8) begin
                push = 1'b1; pv = m_acc[7:0]; m_nbits = 0; m_acc = 0;
            end
        end
        if (pop) void'(m_q.pop_front());
        if (push) begin
            if (m_q.size() < DEPTH) m_q.push_back(pv);
            else                    m_ovf = 1'b1;
        end
    endtask

    task automatic compare_model(input string tag);
        check({tag, "_valid"}, 32'(byte_valid), 32'(m_q.size() > 0));
        check({tag, "_count"}, 32'(fifo_count), 32'(m_q.size()));
        check({tag, "_ovf"},   32'(overflow),   32'(m_ovf));
        check({tag, "_hf"},    32'(health_fail), 32'(m_hf));
        if (m_q.size() > 0) check({tag, "_data"}, 32'(byte_data), 32'(m_q[0]));
    endtask

    // One clock: inputs driven at negedge, sampled 1 time unit after posedge.
    task automatic cycle(input bit bv, input bit b, input bit rdy, input bit clr, input string tag);
        @(negedge clk);
        bit_valid = bv; bit_in = b; byte_ready = rdy; clear_fail = clr;
        @(posedge clk);
        model_step(bv, b, rdy, clr);
        #1;
        compare_model(tag);
    endtask

    // Reset is asserted away from any clock edge; outputs must clear at once.
    task automatic do_reset();
        @(negedge clk);
        bit_valid = 1'b0; bit_in = 1'b0; byte_ready = 1'b0; clear_fail = 1'b0;
        #2 rst_n = 1'b1;
        #1;
        check("async_reset_count", 32'(fifo_count), 32'd0);
        check("async_reset_valid", 32'(byte_valid), 32'd0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
    endtask

    typedef struct {
        bit         bv;
        bit         b;
        bit         rdy;
        bit         clr;
        bit         exp_valid;
        logic [7:0] exp_data;
        int         exp_count;
        bit         exp_ovf;
    } vec_t;

    vec_t       tbl[9];
    logic [7:0] pat;
    logic [7:0] a3;
    bit         prev_b;

    initial begin
        // Table: bits 1,0,1,1,0,0,1,0 then one idle cycle with ready.
        pat = 8'h4D;
        for (int i = 0; i < 8; i++) begin
            tbl[i] = '{1'b1, pat[i], 1'b1, 1'b0, (i == 7), 8'h4D, (i == 7) ? 1 : 0, 1'b0};
        end
        tbl[8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 0, 1'b0};

        // ---------------- reset state ----------------
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_count", 32'(fifo_count), 32'd0);
        check("rst_valid", 32'(byte_valid), 32'd0);
        check("rst_data",  32'(byte_data),  32'd0);
        check("rst_ovf",   32'(overflow),   32'd0);
        check("rst_hf",    32'(health_fail), 32'd0);
        @(negedge clk);
        rst_n = 1'b0;

        // ---------------- table: first byte 0x4D ----------------
        for (int i = 0; i < 9; i++) begin
            cycle(tbl[i].bv, tbl[i].b, tbl[i].rdy, tbl[i].clr, "tbl");
            check("tbl_valid", 32'(byte_valid), 32'(tbl[i].exp_valid));
            check("tbl_count", 32'(fifo_count), 32'(tbl[i].exp_count));
            check("tbl_ovf",   32'(overflow),   32'(tbl[i].exp_ovf));
            if (tbl[i].exp_valid) check("tbl_data", 32'(byte_data), 32'(tbl[i].exp_data));
        end

        // ---------------- overflow with 40 alternating bits ----------------
        do_reset();
        for (int i = 0; i < 40; i++) cycle(1'b1, (i % 2 == 0), 1'b0, 1'b0, "ovf");
        check("ovf_count", 32'(fifo_count), 32'd4);
        check("ovf_flag",  32'(overflow),   32'd1);
        for (int k = 0; k < 4; k++) begin
            check("ovf_drain_data", 32'(byte_data), 32'h55);
            cycle(1'b0, 1'b0, 1'b1, 1'b0, "drain");
        end
        check("drain_empty", 32'(byte_valid), 32'd0);
        check("ovf_sticky",  32'(overflow),   32'd1);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, "clr_ovf");
        check("ovf_cleared", 32'(overflow), 32'd0);

        // ---------------- full FIFO, simultaneous push and pop ----------------
        do_reset();
        for (int i = 0; i < 32; i++) cycle(1'b1, (i % 2 == 0), 1'b0, 1'b0, "full");
        check("full_count", 32'(fifo_count), 32'd4);
        for (int i = 0; i < 7; i++) cycle(1'b1, (i % 2 == 0), 1'b0, 1'b0, "full7");
        cycle(1'b1, 1'b0, 1'b1, 1'b0, "pushpop");
        check("pushpop_count", 32'(fifo_count), 32'd4);
        check("pushpop_ovf",   32'(overflow),   32'd0);

`ifdef RNG_HEALTH_TEST_EN
        // ---------------- repetition-count health test ----------------
        do_reset();
        for (int i = 0; i < 15; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0, "rep15");
        cycle(1'b1, 1'b0, 1'b0, 1'b0, "rep_break");
        check("rep15_hf", 32'(health_fail), 32'd0);
        for (int i = 0; i < 16; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0, "rep16");
        check("rep16_hf",    32'(health_fail),   32'd1);
        check("rep16_state", 32'(dut.r_state),   32'd1);
        check("rep16_count", 32'(fifo_count),    32'd3);
        for (int i = 0; i < 8; i++) cycle(1'b1, (i % 2 == 0), 1'b0, 1'b0, "fail_ign");
        check("fail_ignore_count", 32'(fifo_count), 32'd3);
        cycle(1'b1, 1'b0, 1'b0, 1'b1, "clr_fail");
        check("clr_hf",    32'(health_fail), 32'd0);
        check("clr_ovf",   32'(overflow),    32'd0);
        check("clr_state", 32'(dut.r_state), 32'd0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0, "fail_drain");
        check("post_clr_empty", 32'(fifo_count), 32'd0);
`else
        // ---------------- no health test: long runs pass through ----------------
        do_reset();
        for (int i = 0; i < 32; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0, "ones");
        check("ones_hf",    32'(health_fail), 32'd0);
        check("ones_count", 32'(fifo_count),  32'd4);
        for (int k = 0; k < 4; k++) begin
            check("ones_data", 32'(byte_data), 32'hFF);
            cycle(1'b0, 1'b0, 1'b1, 1'b0, "ones_drain");
        end
`endif

        // ---------------- reset mid-byte ----------------
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0, "part");
        do_reset();
        a3 = 8'hA3;
        for (int i = 0; i < 8; i++) cycle(1'b1, a3[i], 1'b0, 1'b0, "a3");
        check("a3_data",  32'(byte_data),  32'hA3);
        check("a3_count", 32'(fifo_count), 32'd1);

        // ---------------- randomized stream vs model ----------------
        do_reset();
        prev_b = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            bit bv;
            bit b;
            bit rdy;
            bit clr;
            bv  = ($urandom_range(0, 3) != 0);
            b   = ($urandom_range(0, 9) < 8) ? prev_b : !prev_b;
            rdy = (i < 1500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            clr = ($urandom_range(0, 63) == 0);
            prev_b = b;
            cycle(bv, b, rdy, clr, "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_rng_byte_collector
`default_nettype wire
